// File: rtl/sio_mem_engine.sv
// sio_mem_engine: serial packet engine between a byte/flag UART and an SRAM client port.
// Build option: define SIO_MEM_CHECKSUM_EN to append a mod-256 data checksum to read replies.
`timescale 1ns/1ps
module sio_mem_engine #(
  parameter int ADDR_BYTES = 3,
  parameter int WR_WAIT    = 1,
  localparam int ADDR_W    = 8*ADDR_BYTES-4
) (
  input  logic              mclk,
  input  logic              reset,
  input  logic              tx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_data_strobe,
  output logic              tx_flag,
  input  logic [7:0]        rx_data,
  input  logic              rx_data_strobe,
  input  logic              rx_flag,
  output logic              mem_begin_wr,
  output logic              mem_begin_rd,
  input  logic              mem_finish,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data_wr,
  input  logic [7:0]        mem_data_rd,
  output logic              overrun
);

  typedef enum logic [2:0] {RX_ERROR, RX_CMD, RX_ADDR, RX_CNT_HI, RX_CNT_LO, RX_DATA} rx_state_t;
`ifdef SIO_MEM_CHECKSUM_EN
  typedef enum logic [2:0] {TX_IDLE, TX_FLAG, TX_CMD, TX_ADDR, TX_DATA, TX_SUM} tx_state_t;
`else
  typedef enum logic [2:0] {TX_IDLE, TX_FLAG, TX_CMD, TX_ADDR, TX_DATA} tx_state_t;
`endif
  typedef enum logic [1:0] {MEM_IDLE, MEM_READ, MEM_WRITE} mem_state_t;

  localparam logic [3:0] CMD_WRITE  = 4'd1;
  localparam logic [3:0] CMD_READ_N = 4'd5;

  // ---------------- RX: header parse ----------------
  rx_state_t         rx_state_q, rx_state_d;
  logic [3:0]        rx_cmd_q, rx_cmd_d;
  logic [1:0]        rx_cnt_q, rx_cnt_d;
  logic [ADDR_W-1:0] hdr_addr_q, hdr_addr_d;
  logic [7:0]        cnt_hi_q, cnt_hi_d;
  logic              hdr_stb;
  logic [16:0]       hdr_len;
  logic              wr_byte;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cmd_d   = rx_cmd_q;
    rx_cnt_d   = rx_cnt_q;
    hdr_addr_d = hdr_addr_q;
    cnt_hi_d   = cnt_hi_q;
    hdr_stb    = 1'b0;
    wr_byte    = 1'b0;
    if (rx_flag) begin
      rx_state_d = RX_CMD;
    end else if (rx_data_strobe) begin
      case (rx_state_q)
        RX_CMD: begin
          rx_cmd_d   = rx_data[7:4];
          hdr_addr_d = ADDR_W'(rx_data[3:0]);
          rx_cnt_d   = 2'(ADDR_BYTES-1);
          rx_state_d = RX_ADDR;
        end
        RX_ADDR: begin
          // Address builds MSB first by shifting each byte in at the bottom.
          hdr_addr_d = {hdr_addr_q[ADDR_W-9:0], rx_data};
          rx_cnt_d   = rx_cnt_q - 2'd1;
          if (rx_cnt_q == 2'd1) begin
            if (rx_cmd_q == CMD_READ_N) begin
              rx_state_d = RX_CNT_HI;
            end else begin
              hdr_stb    = 1'b1;
              rx_state_d = RX_DATA;
            end
          end
        end
        RX_CNT_HI: begin
          cnt_hi_d   = rx_data;
          rx_state_d = RX_CNT_LO;
        end
        RX_CNT_LO: begin
          hdr_stb    = 1'b1;
          rx_state_d = RX_DATA;
        end
        RX_DATA: wr_byte = (rx_cmd_q == CMD_WRITE);
        default: ;
      endcase
    end
    case (rx_cmd_q)
      4'd2:    hdr_len = 17'd16;
      4'd3:    hdr_len = 17'd1024;
      4'd4:    hdr_len = 17'd65536;
      4'd5:    hdr_len = {1'b0, cnt_hi_q, rx_data} + 17'd1;
      default: hdr_len = '0;
    endcase
  end

  // ---------------- TX: reply sequencer ----------------
  // tx_flag / tx_data_strobe are one-cycle pulses; a new pulse is issued only when tx_ready
  // is high and no pulse was issued in the previous cycle.
  tx_state_t         tx_state_q, tx_state_d;
  logic [3:0]        tx_cmd_q, tx_cmd_d;
  logic [ADDR_W-1:0] tx_sr_q, tx_sr_d;
  logic [1:0]        tx_cnt_q, tx_cnt_d;
  logic [16:0]       tx_len_q, tx_len_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_data_strobe_q, tx_data_strobe_d;
  logic              tx_flag_q, tx_flag_d;
`ifdef SIO_MEM_CHECKSUM_EN
  logic [7:0]        tx_sum_q, tx_sum_d;
`endif
  logic              tx_go;
  logic              pf_take;
  logic              pf_valid_q, pf_valid_d;
  logic [7:0]        pf_data_q, pf_data_d;

  always_comb begin
    tx_state_d       = tx_state_q;
    tx_cmd_d         = tx_cmd_q;
    tx_sr_d          = tx_sr_q;
    tx_cnt_d         = tx_cnt_q;
    tx_len_d         = tx_len_q;
    tx_data_d        = tx_data_q;
    tx_data_strobe_d = 1'b0;
    tx_flag_d        = 1'b0;
`ifdef SIO_MEM_CHECKSUM_EN
    tx_sum_d         = tx_sum_q;
`endif
    pf_take          = 1'b0;
    tx_go            = tx_ready && !tx_data_strobe_q && !tx_flag_q;
    if (hdr_stb) begin
      tx_state_d = TX_FLAG;
      tx_cmd_d   = rx_cmd_q;
      tx_sr_d    = hdr_addr_d;
      tx_cnt_d   = 2'(ADDR_BYTES-1);
      tx_len_d   = hdr_len;
`ifdef SIO_MEM_CHECKSUM_EN
      tx_sum_d   = '0;
`endif
    end else if (tx_go) begin
      case (tx_state_q)
        TX_FLAG: begin
          tx_flag_d  = 1'b1;
          tx_state_d = TX_CMD;
        end
        TX_CMD: begin
          tx_data_d        = {tx_cmd_q, tx_sr_q[ADDR_W-1 -: 4]};
          tx_data_strobe_d = 1'b1;
          tx_sr_d          = tx_sr_q << 4;
          tx_state_d       = TX_ADDR;
        end
        TX_ADDR: begin
          tx_data_d        = tx_sr_q[ADDR_W-1 -: 8];
          tx_data_strobe_d = 1'b1;
          tx_sr_d          = tx_sr_q << 8;
          tx_cnt_d         = tx_cnt_q - 2'd1;
          if (tx_cnt_q == 2'd1) tx_state_d = (tx_len_q == '0) ? TX_IDLE : TX_DATA;
        end
        TX_DATA: begin
          if (pf_valid_q) begin
            tx_data_d        = pf_data_q;
            tx_data_strobe_d = 1'b1;
            pf_take          = 1'b1;
            tx_len_d         = tx_len_q - 17'd1;
`ifdef SIO_MEM_CHECKSUM_EN
            tx_sum_d         = tx_sum_q + pf_data_q;
            if (tx_len_q == 17'd1) tx_state_d = TX_SUM;
`else
            if (tx_len_q == 17'd1) tx_state_d = TX_IDLE;
`endif
          end
        end
`ifdef SIO_MEM_CHECKSUM_EN
        TX_SUM: begin
          tx_data_d        = tx_sum_q;
          tx_data_strobe_d = 1'b1;
          tx_state_d       = TX_IDLE;
        end
`endif
        default: ;
      endcase
    end
  end

  // ---------------- MEM: prefetch reads and held writes ----------------
  mem_state_t        mem_state_q, mem_state_d;
  logic [3:0]        wait_q, wait_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic [7:0]        hold_data_q, hold_data_d;
  logic              hold_valid_q, hold_valid_d;
  logic [7:0]        mem_data_wr_q, mem_data_wr_d;
  logic              mem_begin_wr_q, mem_begin_wr_d;
  logic              mem_begin_rd_q, mem_begin_rd_d;
  logic [16:0]       rd_left_q, rd_left_d;
  logic              epoch_q, epoch_d;
  logic              rd_epoch_q, rd_epoch_d;
  logic              overrun_q, overrun_d;
  logic              hold_drain;

  always_comb begin
    mem_state_d    = mem_state_q;
    wait_d         = wait_q;
    mem_addr_d     = mem_addr_q;
    rd_addr_d      = rd_addr_q;
    wr_addr_d      = wr_addr_q;
    hold_addr_d    = hold_addr_q;
    hold_data_d    = hold_data_q;
    hold_valid_d   = hold_valid_q;
    mem_data_wr_d  = mem_data_wr_q;
    mem_begin_wr_d = 1'b0;
    mem_begin_rd_d = 1'b0;
    rd_left_d      = rd_left_q;
    epoch_d        = epoch_q;
    rd_epoch_d     = rd_epoch_q;
    overrun_d      = overrun_q;
    pf_valid_d     = pf_valid_q;
    pf_data_d      = pf_data_q;
    hold_drain     = 1'b0;
    case (mem_state_q)
      MEM_IDLE: begin
        if (hold_valid_q) begin
          mem_begin_wr_d = 1'b1;
          mem_addr_d     = hold_addr_q;
          mem_data_wr_d  = hold_data_q;
          hold_drain     = 1'b1;
          wait_d         = 4'(WR_WAIT);
          mem_state_d    = MEM_WRITE;
        end else if (!pf_valid_q && rd_left_q != '0 && tx_state_q == TX_DATA) begin
          mem_begin_rd_d = 1'b1;
          mem_addr_d     = rd_addr_q;
          rd_addr_d      = rd_addr_q + ADDR_W'(1);
          rd_left_d      = rd_left_q - 17'd1;
          rd_epoch_d     = epoch_q;
          mem_state_d    = MEM_READ;
        end
      end
      MEM_WRITE: begin
        wait_d = wait_q - 4'd1;
        if (wait_q == 4'd1) mem_state_d = MEM_IDLE;
      end
      MEM_READ: begin
        if (mem_finish) begin
          mem_state_d = MEM_IDLE;
          // Data for a read issued before the latest header belongs to an abandoned reply.
          if (rd_epoch_q == epoch_q) begin
            pf_valid_d = 1'b1;
            pf_data_d  = mem_data_rd;
          end
        end
      end
      default: mem_state_d = MEM_IDLE;
    endcase
    if (pf_take) pf_valid_d = 1'b0;
    if (hold_drain) hold_valid_d = 1'b0;
    // A hold register being drained this cycle can take the next byte.
    if (wr_byte) begin
      if (hold_valid_q && !hold_drain) begin
        overrun_d = 1'b1;
      end else begin
        hold_valid_d = 1'b1;
        hold_addr_d  = wr_addr_q;
        hold_data_d  = rx_data;
      end
      wr_addr_d = wr_addr_q + ADDR_W'(1);
    end
    if (hdr_stb) begin
      epoch_d    = !epoch_q;
      pf_valid_d = 1'b0;
      rd_addr_d  = hdr_addr_d;
      wr_addr_d  = hdr_addr_d;
      rd_left_d  = hdr_len;
    end
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      rx_state_q       <= RX_ERROR;
      rx_cmd_q         <= '0;
      rx_cnt_q         <= '0;
      hdr_addr_q       <= '0;
      cnt_hi_q         <= '0;
      tx_state_q       <= TX_IDLE;
      tx_cmd_q         <= '0;
      tx_sr_q          <= '0;
      tx_cnt_q         <= '0;
      tx_len_q         <= '0;
      tx_data_q        <= '0;
      tx_data_strobe_q <= 1'b0;
      tx_flag_q        <= 1'b0;
`ifdef SIO_MEM_CHECKSUM_EN
      tx_sum_q         <= '0;
`endif
      mem_state_q      <= MEM_IDLE;
      wait_q           <= '0;
      mem_addr_q       <= '0;
      rd_addr_q        <= '0;
      wr_addr_q        <= '0;
      hold_addr_q      <= '0;
      hold_data_q      <= '0;
      hold_valid_q     <= 1'b0;
      mem_data_wr_q    <= '0;
      mem_begin_wr_q   <= 1'b0;
      mem_begin_rd_q   <= 1'b0;
      rd_left_q        <= '0;
      epoch_q          <= 1'b0;
      rd_epoch_q       <= 1'b0;
      overrun_q        <= 1'b0;
      pf_valid_q       <= 1'b0;
      pf_data_q        <= '0;
    end else begin
      rx_state_q       <= rx_state_d;
      rx_cmd_q         <= rx_cmd_d;
      rx_cnt_q         <= rx_cnt_d;
      hdr_addr_q       <= hdr_addr_d;
      cnt_hi_q         <= cnt_hi_d;
      tx_state_q       <= tx_state_d;
      tx_cmd_q         <= tx_cmd_d;
      tx_sr_q          <= tx_sr_d;
      tx_cnt_q         <= tx_cnt_d;
      tx_len_q         <= tx_len_d;
      tx_data_q        <= tx_data_d;
      tx_data_strobe_q <= tx_data_strobe_d;
      tx_flag_q        <= tx_flag_d;
`ifdef SIO_MEM_CHECKSUM_EN
      tx_sum_q         <= tx_sum_d;
`endif
      mem_state_q      <= mem_state_d;
      wait_q           <= wait_d;
      mem_addr_q       <= mem_addr_d;
      rd_addr_q        <= rd_addr_d;
      wr_addr_q        <= wr_addr_d;
      hold_addr_q      <= hold_addr_d;
      hold_data_q      <= hold_data_d;
      hold_valid_q     <= hold_valid_d;
      mem_data_wr_q    <= mem_data_wr_d;
      mem_begin_wr_q   <= mem_begin_wr_d;
      mem_begin_rd_q   <= mem_begin_rd_d;
      rd_left_q        <= rd_left_d;
      epoch_q          <= epoch_d;
      rd_epoch_q       <= rd_epoch_d;
      overrun_q        <= overrun_d;
      pf_valid_q       <= pf_valid_d;
      pf_data_q        <= pf_data_d;
    end
  end

  assign tx_data        = tx_data_q;
  assign tx_data_strobe = tx_data_strobe_q;
  assign tx_flag        = tx_flag_q;
  assign mem_begin_wr   = mem_begin_wr_q;
  assign mem_begin_rd   = mem_begin_rd_q;
  assign mem_addr       = mem_addr_q;
  assign mem_data_wr    = mem_data_wr_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_sio_mem_engine.sv
// Bench for sio_mem_engine: packet-level reply/write model, SRAM responder, directed packets.
`timescale 1ns/1ps
module tb_sio_mem_engine;
  localparam int ADDR_W = 20;
  localparam int LIMIT  = 20000;

  logic              mclk = 1'b0;
  logic              reset;
  logic              tx_ready;
  logic [7:0]        tx_data;
  logic              tx_data_strobe;
  logic              tx_flag;
  logic [7:0]        rx_data;
  logic              rx_data_strobe;
  logic              rx_flag;
  logic              mem_begin_wr;
  logic              mem_begin_rd;
  logic              mem_finish;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data_wr;
  logic [7:0]        mem_data_rd;
  logic              overrun;

  sio_mem_engine #(.ADDR_BYTES(3), .WR_WAIT(15)) dut (
    .mclk(mclk), .reset(reset), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_data_strobe(tx_data_strobe), .tx_flag(tx_flag), .rx_data(rx_data),
    .rx_data_strobe(rx_data_strobe), .rx_flag(rx_flag), .mem_begin_wr(mem_begin_wr),
    .mem_begin_rd(mem_begin_rd), .mem_finish(mem_finish), .mem_addr(mem_addr),
    .mem_data_wr(mem_data_wr), .mem_data_rd(mem_data_rd), .overrun(overrun)
  );

  // ---------------- clock ----------------
  always #5 mclk = ~mclk;

  int checks = 0;
  int errors = 0;
  int rd_lat = 2;
  int rd_seen = 0;
  int wr_seen = 0;
  logic [8:0]  exp_q[$];     // expected tx tokens, bit 8 marks a flag
  logic [8:0]  tx_log[$];    // tokens seen since the latest header
  logic [27:0] exp_wr_q[$];  // expected {addr, data} writes
  logic [7:0]  ref_mem[int]; // model memory contents
  logic [7:0]  sram[int];    // responder memory, updated by DUT writes
  logic [8:0]  tok;
  logic [27:0] wtok;

  function automatic logic [7:0] dflt(int a);
    return 8'(a) ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ref_rd(int a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return dflt(a);
  endfunction

  function automatic logic [7:0] sram_rd(int a);
    if (sram.exists(a)) return sram[a];
    return dflt(a);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- scoreboard / compare ----------------
  always @(negedge mclk) begin
    if (!reset) begin
      if (tx_flag || tx_data_strobe) begin
        tok = tx_flag ? 9'h100 : {1'b0, tx_data};
        tx_log.push_back(tok);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_unexpected actual=%0h required=none", tok);
        end else begin
          check("tx_stream", {23'd0, tok}, {23'd0, exp_q.pop_front()});
        end
      end
      if (mem_begin_wr) begin
        wr_seen++;
        wtok = {mem_addr, mem_data_wr};
        sram[int'(mem_addr)] = mem_data_wr;
        if (exp_wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL wr_unexpected actual=%0h required=none", wtok);
        end else begin
          check("mem_wr", {4'd0, wtok}, {4'd0, exp_wr_q.pop_front()});
        end
      end
      if (mem_begin_rd) rd_seen++;
    end
  end

  // ---------------- SRAM responder ----------------
  initial begin
    int cap;
    mem_finish  = 1'b0;
    mem_data_rd = 8'h00;
    forever begin
      @(negedge mclk);
      if (!reset && mem_begin_rd) begin
        cap = int'(mem_addr);
        repeat (rd_lat) @(posedge mclk);
        #1;
        mem_finish  = 1'b1;
        mem_data_rd = sram_rd(cap);
        check("rd_addr_hold", {12'd0, mem_addr}, cap);
        @(posedge mclk);
        #1;
        mem_finish = 1'b0;
      end
    end
  end

  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge mclk);
      #1;
      tx_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver tasks (entered at posedge+1) ----------------
  task automatic send(logic is_flag, logic [7:0] b, int gap);
    rx_flag        = is_flag;
    rx_data_strobe = !is_flag;
    rx_data        = b;
    @(posedge mclk);
    #1;
    rx_flag        = 1'b0;
    rx_data_strobe = 1'b0;
    repeat (gap) begin
      @(posedge mclk);
      #1;
    end
  endtask

  task automatic header(logic [3:0] cmd, logic [19:0] addr, logic [15:0] cnt);
    int len;
    logic [7:0] b;
    logic [7:0] sum;
    send(1'b1, 8'h00, 0);
    send(1'b0, {cmd, addr[19:16]}, 0);
    send(1'b0, addr[15:8], 0);
    send(1'b0, addr[7:0], 0);
    if (cmd == 4'd5) begin
      send(1'b0, cnt[15:8], 0);
      send(1'b0, cnt[7:0], 0);
    end
    exp_q.delete();
    tx_log.delete();
    exp_q.push_back(9'h100);
    exp_q.push_back({1'b0, cmd, addr[19:16]});
    exp_q.push_back({1'b0, addr[15:8]});
    exp_q.push_back({1'b0, addr[7:0]});
    case (cmd)
      4'd2:    len = 16;
      4'd3:    len = 1024;
      4'd4:    len = 65536;
      4'd5:    len = int'(cnt) + 1;
      default: len = 0;
    endcase
    sum = 8'h00;
    for (int i = 0; i < len; i++) begin
      b = ref_rd((int'(addr) + i) % (1 << ADDR_W));
      exp_q.push_back({1'b0, b});
      sum = sum + b;
    end
`ifdef SIO_MEM_CHECKSUM_EN
    if (len != 0) exp_q.push_back({1'b0, sum});
`endif
  endtask

  task automatic wr_data(logic [19:0] addr, logic [7:0] d, int gap);
    exp_wr_q.push_back({addr, d});
    ref_mem[int'(addr)] = d;
    send(1'b0, d, gap);
  endtask

  task automatic wait_drain(string name);
    int n = 0;
    while ((exp_q.size() != 0 || exp_wr_q.size() != 0) && n < LIMIT) begin
      @(posedge mclk);
      #1;
      n++;
    end
    checks++;
    if (n >= LIMIT) begin
      errors++;
      $display("FAIL %s_timeout actual=%0d required=<%0d left_tx=%0d left_wr=%0d",
               name, n, LIMIT, exp_q.size(), exp_wr_q.size());
      exp_q.delete();
      exp_wr_q.delete();
    end
    repeat (40) begin
      @(posedge mclk);
      #1;
    end
  endtask

  task automatic wait_tokens(string name, int want);
    int n = 0;
    while (tx_log.size() < want && n < LIMIT) begin
      @(posedge mclk);
      #1;
      n++;
    end
    check({name, "_tokens"}, (n < LIMIT) ? 1 : 0, 1);
  endtask

  task automatic reset_checks(string tag);
    @(negedge mclk);
    check({tag, "_tx_data"}, {24'd0, tx_data}, 0);
    check({tag, "_tx_strobes"}, {30'd0, tx_data_strobe, tx_flag}, 0);
    check({tag, "_mem_begin"}, {30'd0, mem_begin_wr, mem_begin_rd}, 0);
    check({tag, "_mem_addr"}, {12'd0, mem_addr}, 0);
    check({tag, "_mem_data_wr"}, {24'd0, mem_data_wr}, 0);
    check({tag, "_overrun"}, {31'd0, overrun}, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rd0;
    int wr0;
    reset          = 1'b1;
    rx_flag        = 1'b0;
    rx_data_strobe = 1'b0;
    rx_data        = 8'h00;
    repeat (3) @(posedge mclk);
    reset_checks("reset");
    @(posedge mclk);
    #1;
    reset = 1'b0;
    repeat (2) begin
      @(posedge mclk);
      #1;
    end

    // Ping
    rd0 = rd_seen; wr0 = wr_seen;
    header(4'd0, 20'h01234, 16'd0);
    wait_drain("ping");
    check("ping_len", tx_log.size(), 4);
    check("ping_tok0", {23'd0, tx_log[0]}, 32'h100);
    check("ping_tok1", {23'd0, tx_log[1]}, 32'h00);
    check("ping_tok2", {23'd0, tx_log[2]}, 32'h12);
    check("ping_tok3", {23'd0, tx_log[3]}, 32'h34);
    check("ping_no_mem", (rd_seen - rd0) + (wr_seen - wr0), 0);

    // Write three bytes then read them back in a 16-byte read
    header(4'd1, 20'h00010, 16'd0);
    wr_data(20'h00010, 8'hAA, 20);
    wr_data(20'h00011, 8'hBB, 20);
    wr_data(20'h00012, 8'hCC, 20);
    wait_drain("write");
    check("write_reply_len", tx_log.size(), 4);
    check("write_reply_cmd", {23'd0, tx_log[1]}, 32'h10);
    header(4'd2, 20'h00010, 16'd0);
    wait_drain("read16");
    check("read16_b0", {23'd0, tx_log[4]}, 32'hAA);
    check("read16_b1", {23'd0, tx_log[5]}, 32'hBB);
    check("read16_b2", {23'd0, tx_log[6]}, 32'hCC);

    // Address wrap on write
    header(4'd1, 20'hFFFFF, 16'd0);
    wr_data(20'hFFFFF, 8'h11, 20);
    wr_data(20'h00000, 8'h22, 20);
    wait_drain("wrap");

    // READ_N with count 2: bytes from 0, 1, 2
    header(4'd5, 20'h00000, 16'd2);
    wait_drain("readn");
    check("readn_b0", {23'd0, tx_log[4]}, 32'h22);
    check("readn_b1", {23'd0, tx_log[5]}, 32'h5B);
    check("readn_b2", {23'd0, tx_log[6]}, 32'h58);
`ifdef SIO_MEM_CHECKSUM_EN
    check("readn_sum", {23'd0, tx_log[7]}, 32'hD5);
    check("readn_len", tx_log.size(), 8);
`else
    check("readn_len", tx_log.size(), 7);
`endif

    // Abort a long read with a ping, then with a fresh read
    rd_lat = 8;
    header(4'd4, 20'h00000, 16'd0);
    wait_tokens("abort1", 9);
    header(4'd0, 20'h01234, 16'd0);
    wait_drain("abort1");
    check("abort1_len", tx_log.size(), 4);
    header(4'd4, 20'h00100, 16'd0);
    wait_tokens("abort2", 9);
    header(4'd2, 20'h00010, 16'd0);
    wait_drain("abort2");
    check("abort2_b0", {23'd0, tx_log[4]}, 32'hAA);
    rd_lat = 2;

    // Overrun: three back-to-back write bytes while the write port is busy
    check("overrun_before", {31'd0, overrun}, 0);
    header(4'd1, 20'h00040, 16'd0);
    wr_data(20'h00040, 8'h11, 0);
    wr_data(20'h00041, 8'h22, 0);
    send(1'b0, 8'h33, 40);
    check("overrun_set", {31'd0, overrun}, 1);
    wr_data(20'h00043, 8'h44, 20);
    wait_drain("overrun");
    check("overrun_skip_addr", {24'd0, sram_rd(32'h42)}, 32'h42 ^ 32'h5A);
    check("overrun_sticky", {31'd0, overrun}, 1);

    // Reset clears everything, including the sticky flag
    reset = 1'b1;
    reset_checks("reset2");
    @(posedge mclk);
    #1;
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
